// File: rtl/mul_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul_sequencer
// Purpose  : Buffers signed operand pairs in a 2-deep FIFO and sequences an
//            external multiplier (CLEAR, START, WAIT) with a timeout watchdog.
// Revision : 1.0 - initial release
// ============================================================================
module mul_sequencer #(
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [63:0]   in_multiplier,
  input  logic [63:0]   in_multiplicand,
  output logic          mul_start,
  output logic          mul_clear,
  output logic [63:0]   mul_multiplier,
  output logic [63:0]   mul_multiplicand,
  input  logic          mul_done,
  input  logic [127:0]  mul_result,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [127:0]  out_result,
  output logic          err
);

  localparam int c_wd_w = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [c_wd_w-1:0] c_wd_last = c_wd_w'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t              r_state;
  logic [c_wd_w-1:0]   r_watchdog;
  logic [63:0]         r_fifo_mplier [2];
  logic [63:0]         r_fifo_mcand  [2];
  logic                r_rd_ptr;
  logic                r_wr_ptr;
  logic [1:0]          r_count;
  logic                w_push;
  logic                w_pop;

  // A full FIFO never accepts, even when the head pops in the same cycle.
  assign in_ready         = (r_count != 2'd2);
  assign w_push           = in_valid && in_ready;
  assign w_pop            = ((r_state == S_WAIT) && mul_done) || (r_state == S_ABORT);
  assign mul_multiplier   = r_fifo_mplier[r_rd_ptr];
  assign mul_multiplicand = r_fifo_mcand[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 2; i++) begin
        r_fifo_mplier[i] <= '0;
        r_fifo_mcand[i]  <= '0;
      end
      r_rd_ptr <= 1'b0;
      r_wr_ptr <= 1'b0;
      r_count  <= 2'd0;
    end else begin
      if (w_push) begin
        r_fifo_mplier[r_wr_ptr] <= in_multiplier;
        r_fifo_mcand[r_wr_ptr]  <= in_multiplicand;
        r_wr_ptr                <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_watchdog <= '0;
      mul_start  <= 1'b0;
      mul_clear  <= 1'b0;
      out_valid  <= 1'b0;
      out_result <= '0;
      err        <= 1'b0;
    end else begin
      mul_start <= 1'b0;
      mul_clear <= 1'b0;
      // A product load later in this block overrides the handshake clear.
      if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
      case (r_state)
        S_IDLE: begin
          if ((r_count != 2'd0) && (!out_valid || out_ready)) begin
            r_state   <= S_CLEAR;
            mul_clear <= 1'b1;
          end
        end
        S_CLEAR: begin
          r_state   <= S_START;
          mul_start <= 1'b1;
        end
        S_START: begin
          r_state    <= S_WAIT;
          r_watchdog <= '0;
        end
        S_WAIT: begin
          if (mul_done) begin
            out_result <= mul_result;
            out_valid  <= 1'b1;
            r_state    <= S_IDLE;
          end else begin
            r_watchdog <= r_watchdog + 1'b1;
            if (r_watchdog == c_wd_last) begin
              r_state   <= S_ABORT;
              mul_clear <= 1'b1;
            end
          end
        end
        S_ABORT: begin
          err     <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: doc/mul_sequencer.md
MUL_SEQUENCER -- requirements
Module: mul_sequencer

Interface
REQ-001 The block SHALL have the parameter TIMEOUT, default 255, giving the maximum WAIT cycles before an abort.
REQ-002 The port clk SHALL be an input, 1 bit wide: the single clock; all state updates on its rising edge.
REQ-003 The port reset SHALL be an input, 1 bit wide: the reset, asynchronous and active-high.
REQ-004 The port in_valid SHALL be an input, 1 bit wide: an operand pair is offered.
REQ-005 The port in_ready SHALL be an output, 1 bit wide: the operand FIFO can accept a pair.
REQ-006 The port in_multiplier SHALL be an input, 64 bits wide: a signed two's-complement operand.
REQ-007 The port in_multiplicand SHALL be an input, 64 bits wide: a signed two's-complement operand.
REQ-008 The port mul_start SHALL be an output, 1 bit wide: the start pulse to the downstream multiplier.
REQ-009 The port mul_clear SHALL be an output, 1 bit wide: the clear pulse to the multiplier.
REQ-010 The port mul_multiplier SHALL be an output, 64 bits wide: the FIFO head multiplier.
REQ-011 The port mul_multiplicand SHALL be an output, 64 bits wide: the FIFO head multiplicand.
REQ-012 The port mul_done SHALL be an input, 1 bit wide: the multiplier completion pulse.
REQ-013 The port mul_result SHALL be an input, 128 bits wide: the signed product from the multiplier.
REQ-014 The port out_valid SHALL be an output, 1 bit wide: out_result holds an undelivered product.
REQ-015 The port out_ready SHALL be an input, 1 bit wide: the consumer accepts the product.
REQ-016 The port out_result SHALL be an output, 128 bits wide: the registered product.
REQ-017 The port err SHALL be an output, 1 bit wide: a sticky timeout flag.

Function
REQ-018 Input transfer SHALL occur on a cycle with in_valid && in_ready; the pair is pushed into a 2-entry FIFO.
REQ-019 in_ready SHALL be 1 exactly when the FIFO holds fewer than 2 entries.
REQ-020 A push and a pop in the same cycle while the FIFO is full SHALL be allowed only if the pop is registered first; when full, in_ready stays 0 that cycle.
REQ-021 mul_multiplier and mul_multiplicand SHALL continuously drive the FIFO head and SHALL stay stable from START until the pop.
REQ-022 The FSM SHALL have the states IDLE, CLEAR, START, WAIT and ABORT.
REQ-023 The IDLE->CLEAR transition SHALL occur when the FIFO is non-empty and (out_valid==0 or out_ready==1).
REQ-024 In CLEAR, mul_clear SHALL be 1 for exactly one cycle, and the next state SHALL be START; this clear is mandatory because it re-arms the multiplier iteration counter.
REQ-025 In START, mul_start SHALL be 1 for exactly one cycle, and the next state SHALL be WAIT; the watchdog SHALL be zeroed.
REQ-026 On mul_done==1 in WAIT, the block SHALL load out_result<=mul_result, set out_valid=1, pop the FIFO and go to IDLE, all in the same edge.
REQ-027 On any cycle in WAIT without mul_done, the watchdog SHALL increment; when it reaches TIMEOUT, the state SHALL go to ABORT.
REQ-028 ABORT SHALL assert mul_clear for one cycle, set err=1, pop the FIFO entry without producing a result, and go to IDLE.
REQ-029 err SHALL remain 1 until reset.
REQ-030 mul_done outside WAIT SHALL be ignored.
REQ-031 The output handshake SHALL clear out_valid on out_valid && out_ready unless a new product loads the same edge; a load takes priority and leaves out_valid=1.
REQ-032 A new operation SHALL never start while an unaccepted product would be overwritten, so no product is lost or duplicated.
REQ-033 mul_start and mul_clear SHALL never be 1 in the same cycle.
REQ-034 The latency from input acceptance (FIFO empty, multiplier idle) to out_valid SHALL be 3 cycles plus the multiplier latency from mul_start to mul_done.

Reset
REQ-035 While reset is 1 (asynchronously), the state SHALL be IDLE and the FIFO SHALL be empty.
REQ-036 While reset is 1, in_ready SHALL be 1.
REQ-037 While reset is 1, mul_start=0, mul_clear=0, out_valid=0, out_result=0 and err=0.
REQ-038 While reset is 1, the watchdog SHALL be 0 and the FIFO head outputs SHALL be 0.
REQ-039 A reset asserted mid-operation SHALL discard all queued and in-flight operands.
REQ-040 After reset releases mid-operation, the first operation SHALL still issue CLEAR before START.

Verification
REQ-041 The bench SHALL check: push 3 x 5, out_ready=1 -> one mul_clear pulse, one mul_start pulse next cycle, then out_result=0x...000F and out_valid for one cycle.
REQ-042 The bench SHALL check: push -2 x 7 -> out_result=0xFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFF2.
REQ-043 The bench SHALL check: push three pairs back-to-back with out_ready=0 -> in_ready drops after 2 accepted; the first product is held; the second operation does not start until out_ready=1.
REQ-044 The bench SHALL check: push 0x7FFF...F x 0x7FFF...F with a real multiplier attached -> out_result=0x3FFF...F_0000...0001, err=0.
REQ-045 The bench SHALL check: mul_done tied 0 -> ABORT after TIMEOUT=255 WAIT cycles, err=1, mul_clear pulsed, FIFO decremented, out_valid=0.
REQ-046 The bench SHALL check: assert reset during WAIT -> all outputs are at reset values immediately; a subsequent push runs CLEAR, START, WAIT normally.
